// File: rtl/ofs_plat_if_pwr_reset_seq_if.sv
// Control bundle between the platform wrapper and the reset/power sequencer.
// The master drives power state and idle status, and the slave (the sequencer) drives channel resets and enables.
interface ofs_plat_if_pwr_reset_seq_if #(
  parameter int NUM_CHAN = 4
);
  logic [1:0]          pwr_state;
  logic                sw_reset_req;
  logic [NUM_CHAN-1:0] chan_idle;
  logic [NUM_CHAN-1:0] chan_reset;
  logic [NUM_CHAN-1:0] chan_en;
  logic [2:0]          seq_state;
  logic                timeout_err;

  modport master (
    output pwr_state, sw_reset_req, chan_idle,
    input  chan_reset, chan_en, seq_state, timeout_err
  );

  modport slave (
    input  pwr_state, sw_reset_req, chan_idle,
    output chan_reset, chan_en, seq_state, timeout_err
  );
endinterface

// File: rtl/ofs_plat_if_pwr_reset_seq.sv
// Per-channel reset and power-state sequencer. It releases channel resets one at a time, throttles
// request issue by power state, and drains traffic before any re-reset or shutdown.
module ofs_plat_if_pwr_reset_seq #(
  parameter int NUM_CHAN          = 4,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES    = 4,
  parameter int QUIESCE_TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  ofs_plat_if_pwr_reset_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_QUIESCE = 3'd3,
    ST_OFF     = 3'd4
  } seq_state_e;

  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int SW = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
  localparam int QW = $clog2(QUIESCE_TIMEOUT + 1);
  localparam int IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [QW-1:0] Q_LAST    = QW'(QUIESCE_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHAN - 1);

  seq_state_e          state_q, state_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]       stagger_cnt_q, stagger_cnt_d;
  logic [QW-1:0]       q_cnt_q, q_cnt_d;
  logic [IW-1:0]       rel_idx_q, rel_idx_d;
  logic [2:0]          duty_cnt_q, duty_cnt_d;
  logic [NUM_CHAN-1:0] chan_reset_q, chan_reset_d;
  logic [NUM_CHAN-1:0] chan_en_q, chan_en_d;
  logic                timeout_err_q, timeout_err_d;

  logic shutdown;
  logic all_idle;
  assign shutdown = (bus.pwr_state == 2'd3);
  assign all_idle = &bus.chan_idle;

  // Issue gate for one duty-cycle slot, common to every channel.
  function automatic logic duty_gate(input logic [1:0] pwr, input logic [2:0] duty);
    case (pwr)
      2'd0:    return 1'b1;
      2'd1:    return duty < 3'd4;
      2'd2:    return duty == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default here, so no path can leave one unassigned and infer a latch.
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    stagger_cnt_d = stagger_cnt_q;
    q_cnt_d       = q_cnt_q;
    rel_idx_d     = rel_idx_q;
    duty_cnt_d    = duty_cnt_q;
    chan_reset_d  = chan_reset_q;
    chan_en_d     = '0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      ST_HOLD: begin
        chan_reset_d = '1;
        if (bus.sw_reset_req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (shutdown) begin
            state_d = ST_OFF;
          end else begin
            state_d       = ST_RELEASE;
            stagger_cnt_d = '0;
            if (STAGGER_CYCLES == 0) begin
              rel_idx_d    = LAST_IDX;
              chan_reset_d = '0;
            end else begin
              rel_idx_d       = '0;
              chan_reset_d[0] = 1'b0;
            end
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      ST_RELEASE: begin
        if (bus.sw_reset_req || shutdown) begin
          state_d = ST_QUIESCE;
          q_cnt_d = '0;
        end else if (rel_idx_q == LAST_IDX) begin
          state_d    = ST_RUN;
          duty_cnt_d = '0;
          chan_en_d  = {NUM_CHAN{duty_gate(bus.pwr_state, 3'd0)}};
        end else if (stagger_cnt_q == STAG_LAST) begin
          stagger_cnt_d           = '0;
          rel_idx_d               = rel_idx_q + IW'(1);
          chan_reset_d[rel_idx_d] = 1'b0;
        end else begin
          stagger_cnt_d = stagger_cnt_q + SW'(1);
        end
      end

      ST_RUN: begin
        chan_reset_d = '0;
        if (bus.sw_reset_req || shutdown) begin
          state_d = ST_QUIESCE;
          q_cnt_d = '0;
        end else begin
          duty_cnt_d = duty_cnt_q + 3'd1;
          chan_en_d  = {NUM_CHAN{duty_gate(bus.pwr_state, duty_cnt_d)}};
        end
      end

      ST_QUIESCE: begin
        // Released channels keep their reset deasserted so they can drain.
        if (all_idle || (q_cnt_q == Q_LAST)) begin
          if (!all_idle) timeout_err_d = 1'b1;
          q_cnt_d      = '0;
          hold_cnt_d   = '0;
          chan_reset_d = '1;
          state_d      = shutdown ? ST_OFF : ST_HOLD;
        end else begin
          q_cnt_d = q_cnt_q + QW'(1);
        end
      end

      ST_OFF: begin
        chan_reset_d = '1;
        if (!shutdown) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end

      default: begin
        state_d      = ST_HOLD;
        hold_cnt_d   = '0;
        chan_reset_d = '1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      stagger_cnt_q <= '0;
      q_cnt_q       <= '0;
      rel_idx_q     <= '0;
      duty_cnt_q    <= '0;
      chan_reset_q  <= '1;
      chan_en_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stagger_cnt_q <= stagger_cnt_d;
      q_cnt_q       <= q_cnt_d;
      rel_idx_q     <= rel_idx_d;
      duty_cnt_q    <= duty_cnt_d;
      chan_reset_q  <= chan_reset_d;
      chan_en_q     <= chan_en_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.chan_reset  = chan_reset_q;
  assign bus.chan_en     = chan_en_q;
  assign bus.seq_state   = state_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ofs_plat_if_pwr_reset_seq.sv
// Scoreboard bench for the reset/power sequencer. The stimulus queues cycle-stamped expectations, and a
// monitor on the falling edge compares each expectation against the selected DUT.
module tb_ofs_plat_if_pwr_reset_seq;

  localparam logic [2:0] S_HOLD = 3'd0, S_REL = 3'd1, S_RUN = 3'd2, S_Q = 3'd3, S_OFF = 3'd4;
  localparam logic [3:0] F = 4'b1111;
  localparam bit DA = 1'b0, DB = 1'b1;

  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] rst;
    logic [3:0] en;
    logic [2:0] st;
    logic       te;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  ofs_plat_if_pwr_reset_seq_if #(.NUM_CHAN(4)) bus_a ();
  ofs_plat_if_pwr_reset_seq_if #(.NUM_CHAN(1)) bus_b ();

  ofs_plat_if_pwr_reset_seq #(
    .NUM_CHAN(4), .RESET_HOLD_CYCLES(16), .STAGGER_CYCLES(4), .QUIESCE_TIMEOUT(1024)
  ) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a)
  );

  ofs_plat_if_pwr_reset_seq #(
    .NUM_CHAN(1), .RESET_HOLD_CYCLES(16), .STAGGER_CYCLES(0), .QUIESCE_TIMEOUT(1024)
  ) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int d, input bit sel, input logic [3:0] rst, input logic [3:0] en,
                           input logic [2:0] st, input logic te, input string name);
    exp_t e;
    e.cyc = cyc + d; e.sel = sel; e.rst = rst; e.en = en; e.st = st; e.te = te; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        logic [3:0] a_rst, a_en;
        logic [2:0] a_st;
        logic       a_te;
        if (sbq[i].sel) begin
          a_rst = {3'b000, bus_b.chan_reset}; a_en = {3'b000, bus_b.chan_en};
          a_st  = bus_b.seq_state;            a_te = bus_b.timeout_err;
        end else begin
          a_rst = bus_a.chan_reset; a_en = bus_a.chan_en;
          a_st  = bus_a.seq_state;  a_te = bus_a.timeout_err;
        end
        n_cmp++;
        if ({a_rst, a_en, a_st, a_te} !== {sbq[i].rst, sbq[i].en, sbq[i].st, sbq[i].te}) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got rst=%b en=%b st=%0d te=%b, want rst=%b en=%b st=%0d te=%b",
                   sbq[i].name, cyc, a_rst, a_en, a_st, a_te,
                   sbq[i].rst, sbq[i].en, sbq[i].st, sbq[i].te);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.pwr_state = 2'd0; bus_a.sw_reset_req = 1'b0; bus_a.chan_idle = 4'b1111;
    bus_b.pwr_state = 2'd0; bus_b.sw_reset_req = 1'b0; bus_b.chan_idle = 1'b1;
    @(negedge clk);

    // Power-on sequence: 16 hold cycles, staggered release, full-rate run.
    expect_at(1,  DA, F,       4'b0, S_HOLD, 1'b0, "t1_reset_state");
    expect_at(16, DA, F,       4'b0, S_HOLD, 1'b0, "t1_hold_last");
    expect_at(17, DA, 4'b1110, 4'b0, S_REL,  1'b0, "t1_rel_b0");
    expect_at(20, DA, 4'b1110, 4'b0, S_REL,  1'b0, "t1_stagger_gap");
    expect_at(21, DA, 4'b1100, 4'b0, S_REL,  1'b0, "t1_rel_b1");
    expect_at(25, DA, 4'b1000, 4'b0, S_REL,  1'b0, "t1_rel_b2");
    expect_at(29, DA, 4'b0000, 4'b0, S_REL,  1'b0, "t1_rel_b3");
    for (int k = 0; k < 8; k++) expect_at(30 + k, DA, 4'b0, F, S_RUN, 1'b0, "t1_run_en");
    tick(1);
    reset_a = 1'b0; reset_b = 1'b0;
    tick(36);

    // Duty throttling: AP1 gives 4 of 8 cycles and AP2 gives 1 of 8, in phase with RUN entry.
    bus_a.pwr_state = 2'd1;
    for (int k = 0; k < 16; k++)
      expect_at(1 + k, DA, 4'b0, ((k % 8) < 4) ? F : 4'b0, S_RUN, 1'b0, "t2_pwr1_duty");
    tick(16);
    bus_a.pwr_state = 2'd2;
    for (int k = 0; k < 16; k++)
      expect_at(1 + k, DA, 4'b0, ((k % 8) == 0) ? F : 4'b0, S_RUN, 1'b0, "t2_pwr2_duty");
    tick(16);
    bus_a.pwr_state = 2'd0;
    expect_at(1, DA, 4'b0, F, S_RUN, 1'b0, "t2_pwr0_back");
    tick(1);

    // Software re-reset: quiesce drains for 6 cycles, then the full hold/release sequence repeats.
    bus_a.chan_idle = 4'b0111; bus_a.sw_reset_req = 1'b1;
    expect_at(1,  DA, 4'b0000, 4'b0, S_Q,    1'b0, "t3_quiesce_entry");
    expect_at(6,  DA, 4'b0000, 4'b0, S_Q,    1'b0, "t3_quiesce_last");
    expect_at(7,  DA, F,       4'b0, S_HOLD, 1'b0, "t3_hold_reassert");
    expect_at(22, DA, F,       4'b0, S_HOLD, 1'b0, "t3_hold_end");
    expect_at(23, DA, 4'b1110, 4'b0, S_REL,  1'b0, "t3_rerelease");
    expect_at(35, DA, 4'b0000, 4'b0, S_REL,  1'b0, "t3_rel_done");
    expect_at(36, DA, 4'b0000, F,    S_RUN,  1'b0, "t3_run_no_timeout");
    tick(1);
    bus_a.sw_reset_req = 1'b0;
    tick(5);
    bus_a.chan_idle = 4'b1111;
    tick(30);

    // Shutdown with a stuck channel: 1024-cycle timeout, then OFF with a sticky error.
    bus_a.pwr_state = 2'd3; bus_a.chan_idle = 4'b1110;
    expect_at(1,    DA, 4'b0000, 4'b0, S_Q,   1'b0, "t4_quiesce_entry");
    expect_at(1024, DA, 4'b0000, 4'b0, S_Q,   1'b0, "t4_quiesce_last");
    expect_at(1025, DA, F,       4'b0, S_OFF, 1'b1, "t4_timeout_off");
    expect_at(1030, DA, F,       4'b0, S_OFF, 1'b1, "t4_off_stays");
    tick(1030);
    bus_a.pwr_state = 2'd0; bus_a.chan_idle = 4'b1111;
    expect_at(1,  DA, F,       4'b0, S_HOLD, 1'b1, "t4_off_to_hold");
    expect_at(17, DA, 4'b1110, 4'b0, S_REL,  1'b1, "t4_release");
    expect_at(29, DA, 4'b0000, 4'b0, S_REL,  1'b1, "t4_rel_done");
    expect_at(30, DA, 4'b0000, F,    S_RUN,  1'b1, "t4_run_sticky");
    tick(30);

    // Idle re-reset quiesces in one cycle, and a reset during RELEASE clears everything.
    bus_a.sw_reset_req = 1'b1;
    expect_at(1,  DA, 4'b0000, 4'b0, S_Q,    1'b1, "t6_quiesce_idle");
    expect_at(2,  DA, F,       4'b0, S_HOLD, 1'b1, "t6_hold");
    expect_at(22, DA, 4'b1100, 4'b0, S_REL,  1'b1, "t6_two_released");
    expect_at(23, DA, F,       4'b0, S_HOLD, 1'b0, "t6_reset_mid_release");
    tick(1);
    bus_a.sw_reset_req = 1'b0;
    tick(21);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0; bus_a.pwr_state = 2'd3;

    // Shutdown requested during HOLD takes effect at the end of the hold, and a re-reset is ignored in OFF.
    expect_at(15, DA, F, 4'b0, S_HOLD, 1'b0, "t7_hold_last_pwr3");
    expect_at(16, DA, F, 4'b0, S_OFF,  1'b0, "t7_hold_to_off");
    tick(17);
    bus_a.sw_reset_req = 1'b1;
    expect_at(1, DA, F, 4'b0, S_OFF, 1'b0, "t7_sw_ignored_off");
    expect_at(3, DA, F, 4'b0, S_OFF, 1'b0, "t7_off_steady");
    tick(1);
    bus_a.sw_reset_req = 1'b0;
    tick(3);

    // Single channel, no stagger: a re-reset in hold cycle 10 stretches the hold to 26 cycles.
    reset_b = 1'b1;
    expect_at(1,  DB, 4'b0001, 4'b0000, S_HOLD, 1'b0, "t5_reset_state");
    expect_at(10, DB, 4'b0001, 4'b0000, S_HOLD, 1'b0, "t5_hold_c10");
    expect_at(11, DB, 4'b0001, 4'b0000, S_HOLD, 1'b0, "t5_hold_restart");
    expect_at(26, DB, 4'b0001, 4'b0000, S_HOLD, 1'b0, "t5_hold_extended");
    expect_at(27, DB, 4'b0000, 4'b0000, S_REL,  1'b0, "t5_release_c27");
    expect_at(28, DB, 4'b0000, 4'b0001, S_RUN,  1'b0, "t5_run");
    tick(1);
    reset_b = 1'b0;
    tick(9);
    bus_b.sw_reset_req = 1'b1;
    tick(1);
    bus_b.sw_reset_req = 1'b0;
    tick(22);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
